// File: rtl/ysyx_22050019_mem_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22050019_mem_pkg
//   Shared definitions for the multi-cycle memory slave.
//   - state_e       : responder FSM encoding (IDLE / BUSY / RESP)
//   - MEM_DW/MEM_MW : data width and byte-mask width of one memory word
//   - CNT_W         : width of the latency counter (LAT is at most 15)
//   - addr_to_word  : byte address -> untruncated word offset from BASE
// ---------------------------------------------------------------------------
package ysyx_22050019_mem_pkg;

   localparam int MEM_DW = 64;
   localparam int MEM_MW = MEM_DW / 8;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Word offset of a byte address relative to the array base. The caller
   // truncates to the index width, which gives the wrap-around behaviour.
   function automatic logic [63:0] addr_to_word(input logic [63:0] addr,
                                                input logic [63:0] base);
      return (addr - base) >> 3;
   endfunction

endpackage

// File: rtl/ysyx_22050019_mem_array.sv
// ---------------------------------------------------------------------------
// ysyx_22050019_mem_array
//   DEPTH x 64-bit single-port memory with byte-masked write and
//   synchronous (registered) read.
//   Ports:
//     clk     in  clock, rising edge
//     en_i    in  access strobe for this cycle
//     we_i    in  1 = masked write, 0 = read
//     idx_i   in  word index
//     wdata_i in  write data
//     wmask_i in  byte enables, bit i covers wdata_i[8i+7:8i]
//     rdata_o out read data, updated only on a read access
// ---------------------------------------------------------------------------
module ysyx_22050019_mem_array
   import ysyx_22050019_mem_pkg::*;
#(
   parameter int DEPTH = 4096,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [AW-1:0]     idx_i,
   input  logic [MEM_DW-1:0] wdata_i,
   input  logic [MEM_MW-1:0] wmask_i,
   output logic [MEM_DW-1:0] rdata_o
);

   logic [MEM_DW-1:0] mem_q [DEPTH];
   logic [MEM_DW-1:0] rdata_q;

   // NOTE: the storage array has no reset; clearing thousands of words in
   // one cycle is neither needed nor mappable onto block RAM.
   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i) begin
            for (int i = 0; i < MEM_MW; i++) begin
               if (wmask_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end else begin
            rdata_q <= mem_q[idx_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ysyx_22050019_mem_slave.sv
// ---------------------------------------------------------------------------
// ysyx_22050019_mem_slave
//   Fixed-latency memory responder with valid/ready request and response
//   channels. One request is accepted in IDLE, held LAT cycles in BUSY, and
//   presented in RESP until the master takes it.
//   Optional feature macro: YSYX_22050019_MEM_ERR_EN
//     defined   -> addresses outside [BASE, BASE+8*DEPTH) respond with
//                  rsp_err=1, rdata=0 and no array write
//     undefined -> no range check, addresses wrap, rsp_err tied 0
//   Ports:
//     clk, rst              clock; asynchronous active-high reset
//     req_valid/req_ready   request handshake (ready only in IDLE)
//     req_we, req_addr      access type and byte address (addr[2:0] ignored)
//     req_wdata, req_wmask  write data and byte enables
//     rsp_valid/rsp_ready   response handshake
//     rsp_rdata, rsp_err    read data (0 for writes) and access error
// ---------------------------------------------------------------------------
module ysyx_22050019_mem_slave
   import ysyx_22050019_mem_pkg::*;
#(
   parameter int          DEPTH = 4096,
   parameter logic [63:0] BASE  = 64'h8000_0000,
   parameter int          LAT   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [63:0]       req_addr,
   input  logic [MEM_DW-1:0] req_wdata,
   input  logic [MEM_MW-1:0] req_wmask,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [MEM_DW-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int AW = $clog2(DEPTH);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q;
   logic              err_q;
   logic [AW-1:0]     idx_q;
   logic [MEM_DW-1:0] wdata_q;
   logic [MEM_MW-1:0] wmask_q;

   logic              req_fire;
   logic              req_err;
   logic [AW-1:0]     req_idx;
   logic              last_busy;
   logic              mem_en;
   logic [MEM_DW-1:0] arr_rdata;

   // Held low while rst is asserted even though the FSM already sits in IDLE.
   assign req_ready = (state_q == ST_IDLE) && !rst;
   assign req_fire  = req_valid && req_ready;
   assign req_idx   = AW'(addr_to_word(req_addr, BASE));

`ifdef YSYX_22050019_MEM_ERR_EN
   assign req_err = (req_addr < BASE) || (req_addr >= BASE + 64'(8 * DEPTH));
`else
   assign req_err = 1'b0;
`endif

   // ---------------- FSM ----------------
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every output of this block is given a default first, so no path
   // leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_fire) begin
               state_d = ST_BUSY;
               cnt_d   = CNT_W'(LAT - 1);
            end
         end
         ST_BUSY: begin
            if (cnt_q == '0) state_d = ST_RESP;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- request capture ----------------
   // Fields are sampled only on the accept edge, so later input changes are
   // invisible to the transaction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
      end else if (req_fire) begin
         we_q    <= req_we;
         err_q   <= req_err;
         idx_q   <= req_idx;
         wdata_q <= req_wdata;
         wmask_q <= req_wmask;
      end
   end

   // ---------------- memory access ----------------
   // The single array access happens on the BUSY->RESP edge: writes commit
   // there and reads land in the array's output register. A reset before
   // that edge forces IDLE, so a pending write never reaches the array.
   assign last_busy = (state_q == ST_BUSY) && (cnt_q == '0);
   assign mem_en    = last_busy && !err_q;

   ysyx_22050019_mem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk     (clk),
      .en_i    (mem_en),
      .we_i    (we_q),
      .idx_i   (idx_q),
      .wdata_i (wdata_q),
      .wmask_i (wmask_q),
      .rdata_o (arr_rdata)
   );

   // ---------------- response ----------------
   // The array output register only changes on a read access, which cannot
   // occur while in RESP, so these stay stable until the handshake.
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_err   = (state_q == ST_RESP) && err_q;
   assign rsp_rdata = ((state_q == ST_RESP) && !we_q && !err_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_ysyx_22050019_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22050019_mem_slave
//   Directed bench for ysyx_22050019_mem_slave with hand-computed
//   expectations. Inputs change 1 time unit after a rising edge; outputs are
//   sampled at that same point, away from the active edge.
//   Honours YSYX_22050019_MEM_ERR_EN for the out-of-range cases.
// ---------------------------------------------------------------------------
module tb_ysyx_22050019_mem_slave;

   localparam int          DEPTH = 4096;
   localparam logic [63:0] BASE  = 64'h8000_0000;
   localparam int          LAT   = 2;
   localparam int          TMO   = 20;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wmask;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_rdata;
   logic        rsp_err;

   int checks = 0;
   int errors = 0;

   ysyx_22050019_mem_slave #(
      .DEPTH (DEPTH),
      .BASE  (BASE),
      .LAT   (LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wmask (req_wmask),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete transaction. bp = cycles rsp_ready is held low after
   // rsp_valid rises; the response must stay frozen during that time.
   task automatic xact(input string tag, input logic we, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [7:0] wmask,
                       input int bp, output logic [63:0] rdata, output logic err);
      int n;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_wmask = wmask;
      rsp_ready = (bp == 0);
      n = 0;
      while (!req_ready && n < TMO) begin
         tick();
         n++;
      end
      check({tag, "_req_ready"}, req_ready, 1'b1);
      tick();  // accept edge
      req_valid = 1'b0;
      req_we    = ~we;
      req_addr  = 64'hFFFF_FFFF_FFFF_FFF8;
      req_wdata = 64'h5A5A_5A5A_5A5A_5A5A;
      req_wmask = 8'hFF;
      n = 0;
      while (!rsp_valid && n < TMO) begin
         tick();
         n++;
      end
      check({tag, "_latency"}, 64'(n), 64'(LAT));
      rdata = rsp_rdata;
      err   = rsp_err;
      for (int i = 0; i < bp; i++) begin
         tick();
         check({tag, "_bp_valid"}, rsp_valid, 1'b1);
         check({tag, "_bp_rdata"}, rsp_rdata, rdata);
         check({tag, "_bp_err"}, rsp_err, err);
         check({tag, "_bp_req_ready"}, req_ready, 1'b0);
      end
      rsp_ready = 1'b1;
      tick();  // response handshake edge
      check({tag, "_done_valid"}, rsp_valid, 1'b0);
      check({tag, "_done_req_ready"}, req_ready, 1'b1);
   endtask

   logic [63:0] rd;
   logic        er;

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_wmask = '0;
      rsp_ready = 1'b1;

      // Reset behaviour
      repeat (3) tick();
      check("rst_req_ready", req_ready, 1'b0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      rst = 1'b0;
      tick();
      check("post_rst_req_ready", req_ready, 1'b1);
      check("post_rst_rsp_valid", rsp_valid, 1'b0);
      check("post_rst_rsp_err", rsp_err, 1'b0);
      check("post_rst_rsp_rdata", rsp_rdata, 64'h0);

      // Full write then read back
      xact("wr_full", 1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0, rd, er);
      check("wr_full_rdata", rd, 64'h0);
      check("wr_full_err", er, 1'b0);
      xact("rd_full", 1'b0, 64'h8000_0010, 64'h0, 8'h00, 0, rd, er);
      check("rd_full_rdata", rd, 64'h1122_3344_5566_7788);
      check("rd_full_err", er, 1'b0);

      // Partial write: low four bytes only
      xact("wr_part", 1'b1, 64'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 0, rd, er);
      xact("rd_part", 1'b0, 64'h8000_0010, 64'h0, 8'h00, 0, rd, er);
      check("rd_part_rdata", rd, 64'h1122_3344_AAAA_AAAA);

      // wmask=0 is a no-op write; addr[2:0] is ignored
      xact("wr_nomask", 1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, rd, er);
      xact("rd_nomask", 1'b0, 64'h8000_0015, 64'h0, 8'h00, 0, rd, er);
      check("rd_nomask_rdata", rd, 64'h1122_3344_AAAA_AAAA);

      // Backpressure: response held 5 cycles
      xact("rd_bp", 1'b0, 64'h8000_0010, 64'h0, 8'h00, 5, rd, er);
      check("rd_bp_rdata", rd, 64'h1122_3344_AAAA_AAAA);

      // Reset in the middle of BUSY drops a pending write
      xact("wr_old", 1'b1, 64'h8000_0020, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, rd, er);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 64'h8000_0020;
      req_wdata = 64'h0000_0000_0000_DEAD;
      req_wmask = 8'hFF;
      tick();  // accept edge
      req_valid = 1'b0;
      check("midrst_busy_req_ready", req_ready, 1'b0);
      tick();  // counter now 0, next edge would commit
      rst = 1'b1;
      #1;
      check("midrst_rsp_valid", rsp_valid, 1'b0);
      check("midrst_req_ready", req_ready, 1'b0);
      tick();
      check("midrst_hold_rsp_valid", rsp_valid, 1'b0);
      rst = 1'b0;
      tick();
      check("midrst_after_req_ready", req_ready, 1'b1);
      check("midrst_after_rsp_valid", rsp_valid, 1'b0);
      xact("rd_old", 1'b0, 64'h8000_0020, 64'h0, 8'h00, 0, rd, er);
      check("rd_old_rdata", rd, 64'h0123_4567_89AB_CDEF);

      // Top word of the array, then out-of-range accesses
      xact("wr_top", 1'b1, BASE + 64'(8 * (DEPTH - 1)), 64'hCAFE_F00D_BEEF_0042, 8'hFF, 0, rd, er);
      xact("rd_below", 1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00, 0, rd, er);
`ifdef YSYX_22050019_MEM_ERR_EN
      check("rd_below_err", er, 1'b1);
      check("rd_below_rdata", rd, 64'h0);
      // Out-of-range write must not alias onto word 2
      xact("wr_above", 1'b1, 64'h8000_8010, 64'h0, 8'hFF, 0, rd, er);
      check("wr_above_err", er, 1'b1);
      xact("rd_w2", 1'b0, 64'h8000_0010, 64'h0, 8'h00, 0, rd, er);
      check("rd_w2_rdata", rd, 64'h1122_3344_AAAA_AAAA);
`else
      check("rd_below_err", er, 1'b0);
      check("rd_below_rdata", rd, 64'hCAFE_F00D_BEEF_0042);
      // BASE + 8*DEPTH + 0x10 wraps to word 2
      xact("rd_above", 1'b0, 64'h8000_8010, 64'h0, 8'h00, 0, rd, er);
      check("rd_above_err", er, 1'b0);
      check("rd_above_rdata", rd, 64'h1122_3344_AAAA_AAAA);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
